// File: rtl/router_out_arbiter.sv
// Wormhole output-port arbiter: round-robin lock per packet with credit flow control.
// Define ROUTER_ARB_WATCHDOG_EN to build in the stall watchdog that breaks stuck locks.
module router_out_arbiter #(
  parameter int NREQ    = 5,
  parameter int CREDITS = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NREQ-1:0]              req_i,
  input  logic [NREQ-1:0]              tail_i,
  input  logic                         credit_i,
  output logic [NREQ-1:0]              gnt_o,
  output logic                         fire_o,
  output logic [$clog2(CREDITS+1)-1:0] credits_o,
  output logic                         busy_o,
  output logic                         wdog_o
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(CREDITS+1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic            fire;
  int              idx;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
    return (int'(v) == NREQ-1) ? '0 : IW'(v + 1'b1);
  endfunction

  // Scan downward so the lowest offset from the pointer is the one that sticks.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int i = NREQ-1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (req_i[idx]) begin
        pick_idx   = IW'(idx);
        pick_found = 1'b1;
      end
    end
  end

  assign fire = (state_q == LOCKED) && req_i[owner_q] && (credits_q != '0) && !rst_i;

`ifdef ROUTER_ARB_WATCHDOG_EN
  localparam int SW = $clog2(TIMEOUT+1);
  logic [SW-1:0] stall_q, stall_d;
  logic          wdog_q, wdog_d;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    credits_d = credits_q;
`ifdef ROUTER_ARB_WATCHDOG_EN
    stall_d   = '0;
    wdog_d    = wdog_q;
`endif
    if (fire && !credit_i)
      credits_d = credits_q - 1'b1;
    else if (credit_i && !fire && (credits_q != CW'(CREDITS)))
      credits_d = credits_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (fire && tail_i[owner_q]) begin
          state_d = IDLE;
          ptr_d   = inc_wrap(owner_q);
        end
`ifdef ROUTER_ARB_WATCHDOG_EN
        else if (!fire) begin
          if (stall_q == SW'(TIMEOUT-1)) begin
            state_d = IDLE;
            ptr_d   = inc_wrap(owner_q);
            wdog_d  = 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      credits_q <= CW'(CREDITS);
`ifdef ROUTER_ARB_WATCHDOG_EN
      stall_q   <= '0;
      wdog_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      credits_q <= credits_d;
`ifdef ROUTER_ARB_WATCHDOG_EN
      stall_q   <= stall_d;
      wdog_q    <= wdog_d;
`endif
    end
  end

  // Outputs are masked while rst_i is high so a mid-packet reset never shows a grant or fire.
  always_comb begin
    gnt_o = '0;
    if ((state_q == LOCKED) && !rst_i) gnt_o[owner_q] = 1'b1;
  end

  assign fire_o    = fire;
  assign credits_o = rst_i ? CW'(CREDITS) : credits_q;
  assign busy_o    = (state_q == LOCKED) && !rst_i;
`ifdef ROUTER_ARB_WATCHDOG_EN
  assign wdog_o    = wdog_q && !rst_i;
`else
  assign wdog_o    = 1'b0;
`endif

endmodule

// File: tb/tb_router_out_arbiter.sv
// Self-checking bench for router_out_arbiter: vector table, directed corner sequences,
// and randomized traffic against a packet-level reference model.
module tb_router_out_arbiter;
  localparam int NREQ    = 5;
  localparam int CREDITS = 4;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req, tail;
  logic       credit;
  logic [4:0] gnt;
  logic       fire, busy, wdog;
  logic [2:0] credits;

  router_out_arbiter #(.NREQ(NREQ), .CREDITS(CREDITS), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .tail_i(tail), .credit_i(credit),
    .gnt_o(gnt), .fire_o(fire), .credits_o(credits), .busy_o(busy), .wdog_o(wdog)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: is a packet in flight, who owns it, where the next search starts.
  int m_locked = 0, m_owner = 0, m_ptr = 0, m_cred = CREDITS, m_wdog = 0, m_stall = 0;

  logic [4:0] obs_gnt;
  logic       obs_fire, obs_busy, obs_wdog;
  logic [2:0] obs_cred;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_update();
    int f;
    f = (m_locked != 0 && req[m_owner] && m_cred > 0) ? 1 : 0;
    if (rst) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = CREDITS; m_wdog = 0; m_stall = 0;
      return;
    end
    if (f == 1 && !credit) m_cred = m_cred - 1;
    else if (f == 0 && credit && m_cred < CREDITS) m_cred = m_cred + 1;
    if (m_locked == 0) begin
      m_stall = 0;
      for (int j = 0; j < NREQ; j++) begin
        if (m_locked == 0 && req[(m_ptr + j) % NREQ]) begin
          m_locked = 1;
          m_owner  = (m_ptr + j) % NREQ;
        end
      end
    end else if (f == 1) begin
      m_stall = 0;
      if (tail[m_owner]) begin
        m_locked = 0;
        m_ptr    = (m_owner + 1) % NREQ;
      end
    end else begin
`ifdef ROUTER_ARB_WATCHDOG_EN
      m_stall = m_stall + 1;
      if (m_stall == TIMEOUT) begin
        m_locked = 0;
        m_ptr    = (m_owner + 1) % NREQ;
        m_wdog   = 1;
        m_stall  = 0;
      end
`endif
    end
  endtask

  // Apply one cycle of inputs, compare outputs at the falling edge, then advance the model.
  task automatic step(input logic r, input logic [4:0] rq, input logic [4:0] tl, input logic cr);
    logic [4:0] e_gnt;
    rst = r; req = rq; tail = tl; credit = cr;
    @(negedge clk);
    obs_gnt = gnt; obs_fire = fire; obs_busy = busy; obs_wdog = wdog; obs_cred = credits;
    e_gnt = '0;
    if (!r && m_locked != 0) e_gnt[m_owner] = 1'b1;
    chk("model gnt", gnt, e_gnt);
    chk("model fire", fire, (!r && m_locked != 0 && rq[m_owner] && m_cred > 0));
    chk("model credits", credits, r ? CREDITS : m_cred);
    chk("model busy", busy, (!r && m_locked != 0));
    chk("model wdog", wdog, (!r && m_wdog != 0));
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic rst; logic [4:0] req; logic [4:0] tail; logic credit;
    logic [4:0] gnt; logic fire; logic [2:0] cred; logic busy;
  } vec_t;

  vec_t vecs[9];
  int   gorder[$];
  int   fires;

  initial begin
    rst = 1'b1; req = '0; tail = '0; credit = 1'b0;
    @(posedge clk); #1;

    // Single-flit packet, credit accounting and saturation.
    vecs[0] = '{1'b1, 5'h00, 5'h00, 1'b0, 5'h00, 1'b0, 3'd4, 1'b0};
    vecs[1] = '{1'b0, 5'h01, 5'h01, 1'b0, 5'h00, 1'b0, 3'd4, 1'b0};
    vecs[2] = '{1'b0, 5'h01, 5'h01, 1'b0, 5'h01, 1'b1, 3'd4, 1'b1};
    vecs[3] = '{1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 1'b0, 3'd3, 1'b0};
    vecs[4] = '{1'b0, 5'h00, 5'h00, 1'b1, 5'h00, 1'b0, 3'd3, 1'b0};
    vecs[5] = '{1'b0, 5'h00, 5'h00, 1'b1, 5'h00, 1'b0, 3'd4, 1'b0};
    vecs[6] = '{1'b0, 5'h02, 5'h02, 1'b0, 5'h00, 1'b0, 3'd4, 1'b0};
    vecs[7] = '{1'b0, 5'h02, 5'h02, 1'b1, 5'h02, 1'b1, 3'd4, 1'b1};
    vecs[8] = '{1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 1'b0, 3'd4, 1'b0};
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].tail, vecs[i].credit);
      chk($sformatf("vec%0d gnt", i), obs_gnt, vecs[i].gnt);
      chk($sformatf("vec%0d fire", i), obs_fire, vecs[i].fire);
      chk($sformatf("vec%0d credits", i), obs_cred, vecs[i].cred);
      chk($sformatf("vec%0d busy", i), obs_busy, vecs[i].busy);
    end

    // All inputs requesting, every flit a tail: round-robin order.
    step(1'b1, 5'h00, 5'h00, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 5'h1f, 5'h1f, 1'b1);
      for (int k = 0; k < NREQ; k++) if (obs_gnt[k]) gorder.push_back(k);
    end
    chk("rr grant count", gorder.size(), 6);
    for (int i = 0; i < 6 && i < gorder.size(); i++)
      chk($sformatf("rr grant %0d", i), gorder[i], (i == 5) ? 0 : i);

    // Owner 2, 6-flit packet with credits exhausted mid-packet.
    step(1'b1, 5'h00, 5'h00, 1'b0);
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 5'h04, (fires == 5) ? 5'h04 : 5'h00, 1'b0);
      if (obs_fire) fires++;
    end
    chk("stall fires", fires, 4);
    chk("stall gnt held", obs_gnt, 5'h04);
    chk("stall no fire", obs_fire, 1'b0);
    chk("stall credits", obs_cred, 3'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 5'h04, (fires == 5) ? 5'h04 : 5'h00, (i == 0 || i == 2));
      if (obs_fire) fires++;
    end
    chk("drain fires", fires, 6);
    chk("drain idle", obs_busy, 1'b0);
    step(1'b0, 5'h00, 5'h00, 1'b0);

    // Reset on the 3rd flit of a 5-flit packet.
    step(1'b1, 5'h00, 5'h00, 1'b0);
    step(1'b0, 5'h02, 5'h00, 1'b0);
    step(1'b0, 5'h02, 5'h00, 1'b0);
    step(1'b0, 5'h02, 5'h00, 1'b0);
    step(1'b1, 5'h02, 5'h00, 1'b0);
    chk("reset no fire", obs_fire, 1'b0);
    step(1'b0, 5'h03, 5'h00, 1'b0);
    chk("post reset gnt", obs_gnt, 5'h00);
    chk("post reset credits", obs_cred, 3'd4);
    chk("post reset busy", obs_busy, 1'b0);
    step(1'b0, 5'h03, 5'h00, 1'b0);
    chk("rearb from 0", obs_gnt, 5'h01);

    // Owner 1 drops its request mid-packet.
    step(1'b1, 5'h00, 5'h00, 1'b0);
    step(1'b0, 5'h02, 5'h00, 1'b0);
    step(1'b0, 5'h02, 5'h00, 1'b0);
    chk("wd first fire", obs_fire, 1'b1);
`ifdef ROUTER_ARB_WATCHDOG_EN
    for (int i = 0; i < TIMEOUT; i++) step(1'b0, 5'h04, 5'h00, 1'b0);
    chk("wd held last stall", obs_gnt, 5'h02);
    step(1'b0, 5'h04, 5'h00, 1'b0);
    chk("wd released", obs_busy, 1'b0);
    chk("wd flag", obs_wdog, 1'b1);
    step(1'b0, 5'h04, 5'h00, 1'b0);
    chk("wd next owner", obs_gnt, 5'h04);
    chk("wd sticky", obs_wdog, 1'b1);
`else
    for (int i = 0; i < TIMEOUT + 4; i++) step(1'b0, 5'h04, 5'h00, 1'b0);
    chk("no wd lock held", obs_gnt, 5'h02);
    chk("no wd busy", obs_busy, 1'b1);
    chk("no wd flag", obs_wdog, 1'b0);
`endif

    // Randomized traffic against the model.
    step(1'b1, 5'h00, 5'h00, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rq, tl;
      rq = 5'($urandom);
      if ($urandom_range(0, 1) == 0) rq = rq & 5'($urandom);
      tl = ($urandom_range(0, 2) == 0) ? 5'h1f : 5'($urandom) & 5'($urandom);
      step($urandom_range(0, 99) == 0, rq, tl, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
